// File: rtl/i2s_tx_master.sv
// I2S transmitter and bus master: serialises 16-bit stereo PCM in Philips format.
// BCK and LRCK are derived from clk by counters; a one-entry holding register decouples the source.
module i2s_tx_master #(
   parameter int BCK_HALF     = 12,
   parameter int SAMPLE_WIDTH = 16,
   parameter int SLOT_BITS    = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [SAMPLE_WIDTH-1:0] sample_l,
   input  logic [SAMPLE_WIDTH-1:0] sample_r,
   input  logic                    sample_valid,
   output logic                    sample_ready,
   output logic                    i2s_bck,
   output logic                    i2s_lrck,
   output logic                    i2s_dout,
   output logic                    frame_start,
   output logic                    underrun
);

   localparam int FRAME_BITS = 2 * SLOT_BITS;
   localparam int CNT_W      = $clog2(BCK_HALF);
   localparam int BIT_W      = $clog2(FRAME_BITS);

   logic [CNT_W-1:0]        bck_cnt;
   logic [BIT_W-1:0]        bit_cnt;
   logic [FRAME_BITS-1:0]   shifter;
   logic                    full;
   logic [SAMPLE_WIDTH-1:0] hold_l, hold_r, last_l, last_r;

   logic                    tc;
   logic                    fall_ev;
   logic                    load;
   logic [BIT_W-1:0]        bit_nxt;
   logic [SAMPLE_WIDTH-1:0] src_l, src_r;
   logic [FRAME_BITS-1:0]   load_word;
   logic [FRAME_BITS-1:0]   shift_nxt;

   always_comb begin
      tc      = (bck_cnt == CNT_W'(BCK_HALF - 1));
      fall_ev = tc && i2s_bck;
      bit_nxt = (bit_cnt == BIT_W'(FRAME_BITS - 1)) ? '0 : bit_cnt + 1'b1;
      load    = fall_ev && (bit_nxt == '0);
      src_l   = full ? hold_l : last_l;
      src_r   = full ? hold_r : last_r;
      // Leading zero is the previous right slot's tail bit: that is the one-BCK Philips delay.
      load_word = '0;
      load_word[FRAME_BITS-2 -: SAMPLE_WIDTH] = src_l;
      load_word[SLOT_BITS-2  -: SAMPLE_WIDTH] = src_r;
      shift_nxt = (bit_nxt == '0) ? load_word : {shifter[FRAME_BITS-2:0], 1'b0};
   end

   // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         bck_cnt      <= '0;
         bit_cnt      <= BIT_W'(FRAME_BITS - 1);
         shifter      <= '0;
         full         <= 1'b0;
         hold_l       <= '0;
         hold_r       <= '0;
         last_l       <= '0;
         last_r       <= '0;
         sample_ready <= 1'b1;
         i2s_bck      <= 1'b0;
         i2s_lrck     <= 1'b0;
         i2s_dout     <= 1'b0;
         frame_start  <= 1'b0;
         underrun     <= 1'b0;
      end else begin
         frame_start <= 1'b0;
         underrun    <= 1'b0;
         bck_cnt     <= tc ? '0 : bck_cnt + 1'b1;
         if (tc) i2s_bck <= !i2s_bck;

         if (fall_ev) begin
            bit_cnt  <= bit_nxt;
            i2s_lrck <= (bit_nxt >= BIT_W'(SLOT_BITS));
            shifter  <= shift_nxt;
            i2s_dout <= shift_nxt[FRAME_BITS-1];
         end

         if (load) begin
            frame_start <= 1'b1;
            if (full) begin
               last_l       <= hold_l;
               last_r       <= hold_r;
               full         <= 1'b0;
               sample_ready <= 1'b1;
            end else begin
               underrun <= 1'b1;
            end
         end

         // Acceptance never coincides with an emptying load since ready is low while full.
         if (sample_valid && sample_ready) begin
            hold_l       <= sample_l;
            hold_r       <= sample_r;
            full         <= 1'b1;
            sample_ready <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_i2s_tx_master.sv
// Directed bench for i2s_tx_master: frame timing, bit placement, handshake, underrun, mid-frame reset.
module tb_i2s_tx_master;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] sample_l = '0;
   logic [15:0] sample_r = '0;
   logic        sample_valid = 1'b0;
   logic        sample_ready, i2s_bck, i2s_lrck, i2s_dout, frame_start, underrun;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [63:0] LR_EXP = 64'hFFFF_FFFF_0000_0000;

   i2s_tx_master dut (
      .clk          (clk),
      .rst          (rst),
      .sample_l     (sample_l),
      .sample_r     (sample_r),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .i2s_bck      (i2s_bck),
      .i2s_lrck     (i2s_lrck),
      .i2s_dout     (i2s_dout),
      .frame_start  (frame_start),
      .underrun     (underrun)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected dout per bit_cnt index k: left MSB at k=1, right MSB at k=33, rest zero.
   function automatic logic [63:0] exp_frame(input logic [15:0] l, input logic [15:0] r);
      logic [63:0] f;
      f = '0;
      for (int i = 0; i < 16; i++) begin
         f[1 + i]  = l[15 - i];
         f[33 + i] = r[15 - i];
      end
      return f;
   endfunction

   task automatic wait_frame(output int n, output bit to);
      n  = 0;
      to = 1'b0;
      do begin
         tick();
         n++;
      end while (!frame_start && n < 2000);
      if (!frame_start) to = 1'b1;
   endtask

   // Called on the frame_start cycle; samples dout/lrck on each of the 64 BCK rises.
   task automatic capture(output logic [63:0] bits, output logic [63:0] lr, output int period,
                          output int high, output int stray, output bit to);
      int   k, t, r1, r2, f1;
      logic prev;
      k = 0; t = 0; r1 = -1; r2 = -1; f1 = -1; stray = 0; to = 1'b0;
      bits = '0; lr = '0; prev = i2s_bck;
      while (k < 64 && !to) begin
         tick();
         t++;
         if (frame_start || underrun) stray++;
         if (!prev && i2s_bck) begin
            bits[k] = i2s_dout;
            lr[k]   = i2s_lrck;
            if (k == 0) r1 = t;
            if (k == 1) r2 = t;
            k++;
         end
         if (prev && !i2s_bck && r1 >= 0 && f1 < 0) f1 = t;
         prev = i2s_bck;
         if (t > 1700) to = 1'b1;
      end
      period = r2 - r1;
      high   = f1 - r1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      n_checks++; if (i2s_bck !== 1'b0) begin n_fail++; $display("FAIL reset_bck: got %b want 0", i2s_bck); end
      n_checks++; if (i2s_lrck !== 1'b0) begin n_fail++; $display("FAIL reset_lrck: got %b want 0", i2s_lrck); end
      n_checks++; if (i2s_dout !== 1'b0) begin n_fail++; $display("FAIL reset_dout: got %b want 0", i2s_dout); end
      n_checks++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_frame_start: got %b want 0", frame_start); end
      n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL reset_underrun: got %b want 0", underrun); end
      n_checks++; if (sample_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", sample_ready); end
   endtask

   task automatic test_first_frame();
      int n, period, high, stray;
      bit to, cto;
      logic [63:0] bits, lr;
      logic [15:0] dec_l, dec_r;
      sample_l = 16'hA5C3; sample_r = 16'h8001; sample_valid = 1'b1;
      rst = 1'b0;
      tick();
      n_checks++; if (sample_ready !== 1'b0) begin n_fail++; $display("FAIL first_accept: ready %b want 0", sample_ready); end
      sample_valid = 1'b0;
      wait_frame(n, to);
      n_checks++;
      if (to || 1 + n != 24) begin n_fail++; $display("FAIL first_frame_start: edge %0d want 24 (timeout=%0d)", 1 + n, to); end
      n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL first_underrun: got %b want 0", underrun); end
      n_checks++; if (sample_ready !== 1'b1) begin n_fail++; $display("FAIL first_ready_after_load: got %b want 1", sample_ready); end
      capture(bits, lr, period, high, stray, cto);
      n_checks++; if (cto) begin n_fail++; $display("FAIL first_capture: timeout got 1 want 0"); end
      n_checks++; if (bits !== exp_frame(16'hA5C3, 16'h8001)) begin n_fail++; $display("FAIL first_bits: got %h want %h", bits, exp_frame(16'hA5C3, 16'h8001)); end
      n_checks++; if (lr !== LR_EXP) begin n_fail++; $display("FAIL first_lrck: got %h want %h", lr, LR_EXP); end
      for (int i = 0; i < 16; i++) begin
         dec_l[15 - i] = (lr[1 + i] == 1'b0) ? bits[1 + i] : 1'bx;
         dec_r[15 - i] = (lr[33 + i] == 1'b1) ? bits[33 + i] : 1'bx;
      end
      n_checks++; if (dec_l !== 16'hA5C3) begin n_fail++; $display("FAIL decode_l: got %h want a5c3", dec_l); end
      n_checks++; if (dec_r !== 16'h8001) begin n_fail++; $display("FAIL decode_r: got %h want 8001", dec_r); end
      n_checks++; if (period != 24) begin n_fail++; $display("FAIL bck_period: got %0d want 24", period); end
      n_checks++; if (high != 12) begin n_fail++; $display("FAIL bck_high: got %0d want 12", high); end
      n_checks++; if (stray != 0) begin n_fail++; $display("FAIL first_stray_pulses: got %0d want 0", stray); end
   endtask

   task automatic test_underrun();
      int n, period, high, stray;
      bit to, cto;
      logic [63:0] bits, lr;
      wait_frame(n, to);
      n_checks++; if (to || n != 12) begin n_fail++; $display("FAIL ur_frame_wait: got %0d want 12 (timeout=%0d)", n, to); end
      n_checks++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL ur_pulse: got %b want 1", underrun); end
      capture(bits, lr, period, high, stray, cto);
      n_checks++; if (cto || bits !== exp_frame(16'hA5C3, 16'h8001)) begin n_fail++; $display("FAIL ur_repeat_bits: got %h want %h", bits, exp_frame(16'hA5C3, 16'h8001)); end
      n_checks++; if (stray != 0) begin n_fail++; $display("FAIL ur_pulse_width: extra pulses %0d want 0", stray); end
      sample_l = 16'h0000; sample_r = 16'hFFFF; sample_valid = 1'b1;
      tick();
      n_checks++; if (sample_ready !== 1'b0) begin n_fail++; $display("FAIL ur_accept: ready %b want 0", sample_ready); end
      sample_valid = 1'b0;
      wait_frame(n, to);
      n_checks++; if (to || underrun !== 1'b0) begin n_fail++; $display("FAIL ur_new_underrun: got %b want 0 (timeout=%0d)", underrun, to); end
      capture(bits, lr, period, high, stray, cto);
      n_checks++; if (cto || bits !== exp_frame(16'h0000, 16'hFFFF)) begin n_fail++; $display("FAIL ur_new_bits: got %h want %h", bits, exp_frame(16'h0000, 16'hFFFF)); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] next_val, l_acc, r_acc;
      logic [15:0] got_l[$];
      logic [15:0] got_r[$];
      int   accepts, ready_hi, starts, k, t, last_fs, gap_bad, ur;
      logic prev, rdy_before;
      next_val = 16'h0100;
      sample_l = next_val; sample_r = ~next_val; sample_valid = 1'b1;
      accepts = 0; ready_hi = 0; starts = 0; k = 0; t = 0; last_fs = 0; gap_bad = 0; ur = 0;
      l_acc = '0; r_acc = '0; prev = i2s_bck;
      while (starts < 9 && t < 9 * 1536 + 200) begin
         rdy_before = sample_ready;
         tick();
         t++;
         if (rdy_before && sample_valid) begin
            accepts++;
            next_val++;
            sample_l = next_val;
            sample_r = ~next_val;
         end
         if (underrun) ur++;
         if (starts >= 1 && sample_ready) ready_hi++;
         if (!prev && i2s_bck) begin
            if (k >= 1 && k <= 16) l_acc = {l_acc[14:0], i2s_dout};
            if (k >= 33 && k <= 48) r_acc = {r_acc[14:0], i2s_dout};
            k++;
         end
         prev = i2s_bck;
         if (frame_start) begin
            if (starts >= 1) begin
               got_l.push_back(l_acc);
               got_r.push_back(r_acc);
               if (t - last_fs != 1536) gap_bad++;
            end
            starts++;
            last_fs = t;
            k = 0;
            if (starts == 9) sample_valid = 1'b0;
         end
      end
      n_checks++; if (starts != 9) begin n_fail++; $display("FAIL b2b_frames: got %0d want 9", starts); end
      n_checks++; if (accepts != 9) begin n_fail++; $display("FAIL b2b_accepts: got %0d want 9", accepts); end
      n_checks++; if (ready_hi != 8) begin n_fail++; $display("FAIL b2b_ready_high_cycles: got %0d want 8", ready_hi); end
      n_checks++; if (gap_bad != 0) begin n_fail++; $display("FAIL b2b_frame_period: bad gaps %0d want 0", gap_bad); end
      n_checks++; if (ur != 0) begin n_fail++; $display("FAIL b2b_underrun: got %0d want 0", ur); end
      for (int i = 0; i < got_l.size(); i++) begin
         n_checks++;
         if (got_l[i] !== 16'h0100 + 16'(i) || got_r[i] !== ~(16'h0100 + 16'(i))) begin
            n_fail++;
            $display("FAIL b2b_frame%0d: got %h/%h want %h/%h", i, got_l[i], got_r[i], 16'h0100 + 16'(i), ~(16'h0100 + 16'(i)));
         end
      end
   endtask

   task automatic test_mid_reset();
      int n, period, high, stray;
      bit to, cto;
      logic [63:0] bits, lr;
      sample_l = 16'h1234; sample_r = 16'h5678; sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
      // 20 falls past the load plus 14 cycles lands mid-high of BCK with bit_cnt=20.
      repeat (20 * 24 + 13) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++; if (i2s_bck !== 1'b0) begin n_fail++; $display("FAIL mid_rst_bck: got %b want 0", i2s_bck); end
      n_checks++; if (i2s_lrck !== 1'b0) begin n_fail++; $display("FAIL mid_rst_lrck: got %b want 0", i2s_lrck); end
      n_checks++; if (i2s_dout !== 1'b0) begin n_fail++; $display("FAIL mid_rst_dout: got %b want 0", i2s_dout); end
      n_checks++; if (sample_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_ready: got %b want 1", sample_ready); end
      wait_frame(n, to);
      n_checks++; if (to || n != 24) begin n_fail++; $display("FAIL mid_rst_frame_start: got %0d want 24 (timeout=%0d)", n, to); end
      n_checks++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL mid_rst_dropped: underrun %b want 1", underrun); end
      capture(bits, lr, period, high, stray, cto);
      n_checks++; if (cto || bits !== 64'h0) begin n_fail++; $display("FAIL mid_rst_bits: got %h want 0", bits); end
      n_checks++; if (lr !== LR_EXP) begin n_fail++; $display("FAIL mid_rst_lrck: got %h want %h", lr, LR_EXP); end
   endtask

   initial begin
      test_reset();
      test_first_frame();
      test_underrun();
      test_back_to_back();
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
